// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and downstream memory signals around mem_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the surrounding core/memory model.
interface mem_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one downstream memory port between instruction fetch and data accesses.
// Data has priority, but a bounded streak of data grants lets a waiting fetch through.
module mem_arbiter #(
    parameter int DMEM_STREAK_MAX = 4,
    parameter int STREAK_W        = $clog2(DMEM_STREAK_MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DMEM_STREAK_MAX);

    state_t              r_state;
    logic [STREAK_W-1:0] r_streak;

    logic        r_i_vld;
    logic [31:0] r_i_addr;
    logic [3:0]  r_i_rmask;

    logic        r_d_vld;
    logic [31:0] r_d_addr;
    logic [3:0]  r_d_rmask;
    logic [3:0]  r_d_wmask;
    logic [31:0] r_d_wdata;

    logic        w_i_req, w_d_req;
    logic        w_i_new, w_d_new;
    logic        w_i_cand, w_d_cand;
    logic        w_arb, w_grant_i, w_grant_d;
    logic [31:0] w_i_addr, w_d_addr, w_d_wdata;
    logic [3:0]  w_i_rmask, w_d_rmask, w_d_wmask;

    assign w_i_req = |bus.imem_rmask;
    assign w_d_req = |(bus.dmem_rmask | bus.dmem_wmask);

    // A port that is still waiting for its response may not queue another request.
    assign w_i_new = w_i_req && !r_i_vld && !((r_state == BUSY_I) && !bus.mem_resp);
    assign w_d_new = w_d_req && !r_d_vld && !((r_state == BUSY_D) && !bus.mem_resp);

    assign w_i_cand = r_i_vld || w_i_new;
    assign w_d_cand = r_d_vld || w_d_new;

    assign w_arb     = (r_state == IDLE) || bus.mem_resp;
    assign w_grant_d = w_arb && w_d_cand && (!w_i_cand || (r_streak != STREAK_MAX));
    assign w_grant_i = w_arb && w_i_cand && !w_grant_d;

    assign w_i_addr  = r_i_vld ? r_i_addr  : bus.imem_addr;
    assign w_i_rmask = r_i_vld ? r_i_rmask : bus.imem_rmask;
    assign w_d_addr  = r_d_vld ? r_d_addr  : bus.dmem_addr;
    assign w_d_rmask = r_d_vld ? r_d_rmask : bus.dmem_rmask;
    assign w_d_wmask = r_d_vld ? r_d_wmask : bus.dmem_wmask;
    assign w_d_wdata = r_d_vld ? r_d_wdata : bus.dmem_wdata;

    assign bus.imem_resp  = bus.mem_resp && (r_state == BUSY_I);
    assign bus.dmem_resp  = bus.mem_resp && (r_state == BUSY_D);
    assign bus.imem_rdata = bus.mem_rdata;
    assign bus.dmem_rdata = bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_streak      <= '0;
            r_i_vld       <= 1'b0;
            r_i_addr      <= '0;
            r_i_rmask     <= '0;
            r_d_vld       <= 1'b0;
            r_d_addr      <= '0;
            r_d_rmask     <= '0;
            r_d_wmask     <= '0;
            r_d_wdata     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_rmask <= '0;
            bus.mem_wmask <= '0;
            bus.mem_wdata <= '0;
        end else begin
            // Masks are one-cycle issue strobes; address and data hold until the next grant.
            bus.mem_rmask <= '0;
            bus.mem_wmask <= '0;
            if (w_grant_d) begin
                bus.mem_addr  <= w_d_addr;
                bus.mem_rmask <= w_d_rmask;
                bus.mem_wmask <= w_d_wmask;
                bus.mem_wdata <= w_d_wdata;
                r_state       <= BUSY_D;
            end else if (w_grant_i) begin
                bus.mem_addr  <= w_i_addr;
                bus.mem_rmask <= w_i_rmask;
                bus.mem_wdata <= '0;
                r_state       <= BUSY_I;
            end else if (w_arb) begin
                r_state <= IDLE;
            end

            if (w_grant_i) begin
                r_i_vld <= 1'b0;
            end else if (w_i_new) begin
                r_i_vld   <= 1'b1;
                r_i_addr  <= bus.imem_addr;
                r_i_rmask <= bus.imem_rmask;
            end

            if (w_grant_d) begin
                r_d_vld <= 1'b0;
            end else if (w_d_new) begin
                r_d_vld   <= 1'b1;
                r_d_addr  <= bus.dmem_addr;
                r_d_rmask <= bus.dmem_rmask;
                r_d_wmask <= bus.dmem_wmask;
                r_d_wdata <= bus.dmem_wdata;
            end

            if (!w_i_cand || w_grant_i) begin
                r_streak <= '0;
            end else if (w_grant_d && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single unified memory port between the core's instruction-fetch port (imem_*) and data port (dmem_*).
- Sits between the cpu top level and the memory/cache subsystem.
- Latches single-cycle requests from each side, arbitrates with data-priority plus an anti-starvation limit, issues one transaction at a time downstream, and routes the response back to the owning requester.

Parameters:
- DMEM_STREAK_MAX, 4: max consecutive dmem grants while an imem request is waiting; 1..15.
- STREAK_W, $clog2(DMEM_STREAK_MAX+1): streak counter width (derived, do not override).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  in  32  fetch address
- imem_rmask  in  4  fetch byte mask; nonzero = request this cycle (single-cycle pulse)
- imem_rdata  out  32  fetch data, valid when imem_resp=1
- imem_resp  out  1  one-cycle fetch completion
- dmem_addr  in  32  data address
- dmem_rmask  in  4  load mask
- dmem_wmask  in  4  store mask; (rmask|wmask)!=0 = request this cycle (single-cycle pulse)
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, valid when dmem_resp=1
- dmem_resp  out  1  one-cycle data completion
- mem_addr  out  32  downstream address (registered)
- mem_rmask  out  4  downstream read mask, nonzero one cycle per issue (registered)
- mem_wmask  out  4  downstream write mask, nonzero one cycle per issue (registered)
- mem_wdata  out  32  downstream write data (registered)
- mem_rdata  in  32  downstream read data
- mem_resp  in  1  downstream completion pulse, at least 1 cycle after issue

Behaviour:
- Reset: the following are all 0 and the FSM is IDLE:
  - mem_addr, mem_rmask, mem_wmask, mem_wdata
  - both pending slots
  - streak counter
  - imem_resp, dmem_resp
- Reset is asynchronous and may assert mid-transaction. The in-flight transaction is abandoned. Any mem_resp arriving after reset is ignored.
- Pending slots, one per port:
  - Each slot holds addr/masks/wdata plus a valid bit.
  - A request pulse loads the slot on the next edge unless the request is granted in the same cycle (bypass).
  - A port issues at most one outstanding request. A new request while that port's slot is valid or in flight is a protocol violation and is ignored.
- Candidate set each arbitration cycle: valid slots plus requests arriving this cycle.
- FSM states:
  - IDLE: if a candidate exists, grant it, register mem_* on the edge, and go to BUSY_I or BUSY_D. Request at cycle N with IDLE state gives mem_* visible at N+1.
  - BUSY_I / BUSY_D: mem_* masks drop to 0 after one cycle; addr/wdata hold. Wait for mem_resp.
  - On mem_resp, route it to the owner combinationally:
    - imem_resp or dmem_resp = mem_resp while in the matching state.
    - imem_rdata and dmem_rdata = mem_rdata, driven always; meaningful only with resp.
  - In the same cycle as mem_resp, re-arbitrate among candidates.
    - If one exists, the next issue registers on that edge (back-to-back, zero idle cycles).
    - Otherwise go to IDLE.
  - A port may issue its next request in the same cycle its resp is asserted. That request is a legal candidate in that cycle.
- Priority:
  - dmem wins when both are candidates, unless streak == DMEM_STREAK_MAX, in which case imem wins.
  - streak increments on each dmem grant made while an imem candidate exists, saturating at DMEM_STREAK_MAX.
  - streak clears on any imem grant, or in any cycle with no imem candidate.
- mem_resp while IDLE is ignored: no requester resp, no state change.
- Read/write: downstream masks are copied from the granted request as-is. Both rmask and wmask nonzero on dmem is passed through unchanged (downstream defines it).

Test Plan:
- Reset mid-transaction: imem request 0x0000_1000 rmask 0xF, then rst pulse before mem_resp, then mem_resp → all outputs 0, imem_resp never asserts, FSM IDLE.
- Single fetch: imem req addr 0x0000_0040 at cycle N → mem_addr=0x40, mem_rmask=0xF at N+1 only; mem_resp with mem_rdata=0xDEADBEEF at N+3 → imem_resp=1, imem_rdata=0xDEADBEEF at N+3, dmem_resp=0.
- Simultaneous requests: imem 0x100 and dmem store 0x2000/wmask 0x3/wdata 0x1234 at same cycle → store issued first (mem_wmask=0x3, mem_wdata=0x1234). On its mem_resp, fetch 0x100 issues next edge; dmem_resp then imem_resp.
- Back-to-back: dmem load resp cycle coincides with new dmem request 0x3004 → mem_rmask for 0x3004 nonzero the very next cycle, no IDLE gap.
- Starvation: imem waiting, dmem re-requests each resp cycle, DMEM_STREAK_MAX=4 → grant order D,D,D,D,I,D…; streak=0 after the imem grant.
- Stray response: mem_resp pulsed while IDLE → imem_resp=dmem_resp=0, next request serviced normally.
